// File: rtl/orbit_pkg.sv
// Shared constants, FSM state type and sine-table generator for the orbit position source.
package orbit_pkg;

    localparam logic [7:0] KEY_CW  = 8'h07;
    localparam logic [7:0] KEY_CCW = 8'h04;

    localparam int STEPS_DEFAULT  = 60;
    localparam int RADIUS_DEFAULT = 80;
    localparam int CX_DEFAULT     = 320;
    localparam int CY_DEFAULT     = 240;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_STEP = 3'd1,
        ST_MRX  = 3'd2,
        ST_MRY  = 3'd3,
        ST_MBX  = 3'd4,
        ST_MBY  = 3'd5,
        ST_OUT  = 3'd6
    } orbit_state_e;

    // pi scaled by 2^30, used by the elaboration-time sine evaluation
    localparam longint PI_FP = 64'sd3373259426;

    // round(256*sin(2*pi*k/steps)) as 10-bit two's complement, integer-only so it
    // folds to a constant in any tool. Angle is folded into the first quadrant and
    // evaluated with a Taylor series in 2^30 fixed point.
    function automatic logic [9:0] sin_entry(input int k, input int steps);
        longint q, kk, x, x2, term, acc, mag;
        bit     neg;
        logic [9:0] res;
        res = '0;
        if (steps >= 4 && k < steps) begin
            q = longint'(steps / 4);
            if (k <= q) begin
                kk  = longint'(k);
                neg = 1'b0;
            end else if (k <= 2 * q) begin
                kk  = 2 * q - longint'(k);
                neg = 1'b0;
            end else if (k <= 3 * q) begin
                kk  = longint'(k) - 2 * q;
                neg = 1'b1;
            end else begin
                kk  = 4 * q - longint'(k);
                neg = 1'b1;
            end
            x    = (PI_FP * kk) / (2 * q);
            x2   = (x * x) >>> 30;
            term = x;
            acc  = x;
            for (int n = 1; n <= 7; n++) begin
                term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
                acc  = acc + term;
            end
            mag = (acc * 256 + (64'sd1 <<< 29)) >>> 30;
            res = neg ? 10'(-mag) : 10'(mag);
        end
        return res;
    endfunction

    // Packs the whole 64-entry table; entries at or beyond steps are zero.
    function automatic logic [639:0] sin_table(input int steps);
        logic [639:0] tbl;
        tbl = '0;
        for (int k = 0; k < 64; k++) begin
            if (k < steps) tbl[k*10 +: 10] = sin_entry(k, steps);
        end
        return tbl;
    endfunction

endpackage

// File: rtl/orbit_sin_rom.sv
// Combinational sine ROM: 6-bit angle index in, 10-bit signed sample (256 = 1.0) out.
module orbit_sin_rom
    import orbit_pkg::*;
#(
    parameter int STEPS = STEPS_DEFAULT
) (
    input  logic [5:0]        addr,
    output logic signed [9:0] data
);

    localparam logic [639:0] TABLE = sin_table(STEPS);

    assign data = signed'(TABLE[addr*10 +: 10]);

endmodule

// File: rtl/orbit_pos_gen.sv
// Per-frame orbit position source: steps the shared angle index from the keycode and
// computes red/blue ball centres with one sine ROM and one multiplier.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for frame_tick; idx is stepped on the exit edge
// STEP    | new idx visible; slot that keeps tick-to-valid at 6 cycles
// MRX     | red X  = CX + R*cos(idx)         -> shadow
// MRY     | red Y  = CY + R*sin(idx)         -> shadow
// MBX     | blue X = CX + R*cos(idx+STEPS/2) -> shadow
// MBY     | blue Y = CY + R*sin(idx+STEPS/2) -> shadow and outputs
// OUT     | outputs hold the new set, pos_valid high
module orbit_pos_gen
    import orbit_pkg::*;
#(
    parameter int STEPS  = STEPS_DEFAULT,
    parameter int RADIUS = RADIUS_DEFAULT,
    parameter int CX     = CX_DEFAULT,
    parameter int CY     = CY_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    output logic [9:0] RedX,
    output logic [9:0] RedY,
    output logic [9:0] BlueX,
    output logic [9:0] BlueY,
    output logic [5:0] angle_idx,
    output logic       pos_valid
);

    localparam logic [5:0]         LAST     = 6'(STEPS - 1);
    localparam logic [6:0]         STEPS7   = 7'(STEPS);
    localparam logic [6:0]         OFF_COS  = 7'(STEPS / 4);
    localparam logic [6:0]         OFF_HALF = 7'(STEPS / 2);
    localparam logic [6:0]         OFF_BCOS = 7'((3 * STEPS) / 4);
    localparam logic signed [17:0] RAD18    = 18'(RADIUS);
    localparam logic [9:0]         CX10     = 10'(CX);
    localparam logic [9:0]         CY10     = 10'(CY);
    localparam logic [9:0]         RST_RX   = 10'(CX + RADIUS);
    localparam logic [9:0]         RST_BX   = 10'(CX - RADIUS);

    logic [1:0]          rst_sync;
    logic                rst_n;
    orbit_state_e        state;
    logic [5:0]          idx;
    logic [5:0]          next_idx;
    logic [9:0]          sh_rx, sh_ry, sh_bx, sh_by;
    logic [6:0]          off;
    logic [6:0]          sum;
    logic [5:0]          rom_addr;
    logic [9:0]          base;
    logic signed [9:0]   trig;
    logic signed [17:0]  trig_ext;
    logic signed [17:0]  prod;
    logic signed [17:0]  prod_rnd;
    logic signed [9:0]   term;
    logic [9:0]          coord;

    // Reset asserts immediately but releases only after two clean clock edges
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // Keycode decides the next angle index, wrapping at both ends
    always_comb begin
        next_idx = idx;
        if (keycode == KEY_CW)       next_idx = (idx == LAST) ? 6'd0 : idx + 6'd1;
        else if (keycode == KEY_CCW) next_idx = (idx == 6'd0) ? LAST : idx - 6'd1;
    end

    // ROM address offset (cos = sin shifted a quarter turn, blue = half turn) and centre per state
    always_comb begin
        off  = 7'd0;
        base = CX10;
        case (state)
            ST_MRX: begin off = OFF_COS;  base = CX10; end
            ST_MRY: begin off = 7'd0;     base = CY10; end
            ST_MBX: begin off = OFF_BCOS; base = CX10; end
            ST_MBY: begin off = OFF_HALF; base = CY10; end
            default: begin off = 7'd0;    base = CX10; end
        endcase
    end

    assign sum      = {1'b0, idx} + off;
    assign rom_addr = (sum >= STEPS7) ? 6'(sum - STEPS7) : sum[5:0];

    orbit_sin_rom #(.STEPS(STEPS)) u_rom (
        .addr (rom_addr),
        .data (trig)
    );

    // Shared multiplier with round-half-up scaling; the coordinate is the low 10 bits
    // of the 11-bit signed sum, which a 10-bit modular add produces directly.
    assign trig_ext = {{8{trig[9]}}, trig};
    assign prod     = RAD18 * trig_ext;
    assign prod_rnd = prod + 18'sd128;
    assign term     = 10'(prod_rnd >>> 8);
    assign coord    = base + term;

    // Sequencer: index step, four multiplies into shadows, then publish
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= 6'd0;
            sh_rx <= 10'd0;
            sh_ry <= 10'd0;
            sh_bx <= 10'd0;
            sh_by <= 10'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        idx   <= next_idx;
                        state <= ST_STEP;
                    end
                end
                ST_STEP: state <= ST_MRX;
                ST_MRX: begin
                    sh_rx <= coord;
                    state <= ST_MRY;
                end
                ST_MRY: begin
                    sh_ry <= coord;
                    state <= ST_MBX;
                end
                ST_MBX: begin
                    sh_bx <= coord;
                    state <= ST_MBY;
                end
                ST_MBY: begin
                    sh_by <= coord;
                    state <= ST_OUT;
                end
                ST_OUT:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // All four outputs load together on the edge into OUT; blue Y bypasses its shadow
    // so the new set is already on the pins during the OUT cycle.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            RedX  <= RST_RX;
            RedY  <= CY10;
            BlueX <= RST_BX;
            BlueY <= CY10;
        end else if (state == ST_MBY) begin
            RedX  <= sh_rx;
            RedY  <= sh_ry;
            BlueX <= sh_bx;
            BlueY <= coord;
        end
    end

    assign angle_idx = idx;
    assign pos_valid = (state == ST_OUT);

endmodule

// File: tb/tb_orbit_pos_gen.sv
// Self-checking bench for orbit_pos_gen: directed scenarios plus randomized ticks,
// checked against a trigonometric reference model.
module tb_orbit_pos_gen;

    localparam int  STEPS  = 60;
    localparam int  RADIUS = 80;
    localparam int  CX     = 320;
    localparam int  CY     = 240;
    localparam real PI     = 3.14159265358979323846;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [9:0] RedX, RedY, BlueX, BlueY;
    logic [5:0] angle_idx;
    logic       pos_valid;

    int n_checks = 0;
    int n_errors = 0;
    int m_idx    = 0;

    always #5 Clk = ~Clk;

    orbit_pos_gen #(
        .STEPS  (STEPS),
        .RADIUS (RADIUS),
        .CX     (CX),
        .CY     (CY)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .keycode    (keycode),
        .RedX       (RedX),
        .RedY       (RedY),
        .BlueX      (BlueX),
        .BlueY      (BlueY),
        .angle_idx  (angle_idx),
        .pos_valid  (pos_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rnd(input real v);
        return $rtoi($floor(v + 0.5));
    endfunction

    function automatic int scaled(input int tr);
        return $rtoi($floor((RADIUS * tr + 128) / 256.0));
    endfunction

    // Ideal circle positions for red at angle index i and blue half a turn away
    task automatic exp_pos(input int i, output int rx, output int ry, output int bx, output int by);
        real a, b;
        a  = 2.0 * PI * i / STEPS;
        b  = a + PI;
        rx = (CX + scaled(rnd(256.0 * $cos(a)))) & 1023;
        ry = (CY + scaled(rnd(256.0 * $sin(a)))) & 1023;
        bx = (CX + scaled(rnd(256.0 * $cos(b)))) & 1023;
        by = (CY + scaled(rnd(256.0 * $sin(b)))) & 1023;
    endtask

    task automatic model_step(input logic [7:0] key);
        if (key == 8'h07)      m_idx = (m_idx + 1) % STEPS;
        else if (key == 8'h04) m_idx = (m_idx + STEPS - 1) % STEPS;
    endtask

    task automatic check_fixed(input string tag, input int i, input int rx, input int ry,
                               input int bx, input int by);
        check_eq({tag, ".idx"}, angle_idx, i);
        check_eq({tag, ".rx"}, RedX, rx);
        check_eq({tag, ".ry"}, RedY, ry);
        check_eq({tag, ".bx"}, BlueX, bx);
        check_eq({tag, ".by"}, BlueY, by);
    endtask

    // Issues one tick at the current negedge and watches the following 7 cycles.
    // ghost (1..6) raises a second CW tick in that cycle, which must be dropped.
    task automatic send_tick(input logic [7:0] key, input int ghost);
        int prx, pry, pbx, pby, nrx, nry, nbx, nby;
        exp_pos(m_idx, prx, pry, pbx, pby);
        frame_tick = 1'b1;
        keycode    = key;
        model_step(key);
        exp_pos(m_idx, nrx, nry, nbx, nby);
        for (int k = 1; k <= 7; k++) begin
            @(negedge Clk);
            frame_tick = (k == ghost);
            keycode    = (k == ghost) ? 8'h07 : 8'($urandom);
            check_eq("tick.idx", angle_idx, m_idx);
            check_eq("tick.valid", pos_valid, (k == 6) ? 1 : 0);
            if (k < 6) begin
                check_eq("hold.rx", RedX, prx);
                check_eq("hold.ry", RedY, pry);
                check_eq("hold.bx", BlueX, pbx);
                check_eq("hold.by", BlueY, pby);
            end else begin
                check_eq("new.rx", RedX, nrx);
                check_eq("new.ry", RedY, nry);
                check_eq("new.bx", BlueX, nbx);
                check_eq("new.by", BlueY, nby);
            end
        end
        frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        frame_tick = 1'b0;
        Reset      = 1'b0;
        m_idx      = 0;
        repeat (2) @(negedge Clk);
        check_fixed("rst", 0, CX + RADIUS, CY, CX - RADIUS, CY);
        check_eq("rst.valid", pos_valid, 0);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check_fixed("rst_rel", 0, CX + RADIUS, CY, CX - RADIUS, CY);
        check_eq("rst_rel.valid", pos_valid, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();

        repeat (15) send_tick(8'h07, 0);
        check_fixed("cw15", 15, 320, 320, 320, 160);

        apply_reset();
        send_tick(8'h04, 0);
        check_fixed("ccw1", 59, 400, 232, 240, 248);

        apply_reset();
        repeat (60) send_tick(8'h07, 0);
        check_fixed("cw60", 0, 400, 240, 240, 240);
        repeat (60) send_tick(8'h04, 0);
        check_fixed("ccw60", 0, 400, 240, 240, 240);

        send_tick(8'h07, 0);
        send_tick(8'h00, 0);
        check_eq("nokey.idx", angle_idx, 1);

        send_tick(8'h07, 3);
        check_eq("ghost.idx", angle_idx, 2);

        // Reset pulsed while the blue X multiply is in flight
        send_tick(8'h07, 0);
        @(negedge Clk);
        frame_tick = 1'b1;
        keycode    = 8'h07;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            frame_tick = 1'b0;
        end
        Reset = 1'b0;
        m_idx = 0;
        #1;
        check_fixed("midrst", 0, CX + RADIUS, CY, CX - RADIUS, CY);
        check_eq("midrst.valid", pos_valid, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge Clk);
            check_eq("midrst.novalid", pos_valid, 0);
        end
        check_fixed("midrst_after", 0, CX + RADIUS, CY, CX - RADIUS, CY);

        for (int t = 0; t < 150; t++) begin
            int         r;
            int         g;
            logic [7:0] key;
            r = $urandom_range(0, 9);
            if (r < 4)      key = 8'h07;
            else if (r < 7) key = 8'h04;
            else            key = 8'($urandom);
            g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            send_tick(key, g);
            repeat ($urandom_range(0, 3)) @(negedge Clk);
        end
        check_eq("rand.final_idx", angle_idx, m_idx);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
